// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder (dm_resp) and its word store.
package dm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_t;

  localparam int DM_WORD_W   = 32;
  localparam int DM_WAIT_MAX = 15;

  // Byte i of the result comes from new_w when be[i] is set, otherwise from old_w.
  function automatic logic [DM_WORD_W-1:0] dm_byte_merge(
    input logic [DM_WORD_W-1:0] old_w,
    input logic [DM_WORD_W-1:0] new_w,
    input logic [3:0]           be
  );
    logic [DM_WORD_W-1:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_store.sv
// Word array for dm_resp: one synchronous write port, one asynchronous read port,
// whole-array clear on reset.
module dm_store
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DM_WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DM_WORD_W-1:0] rdata
);

  logic [DM_WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_resp.sv
// Handshaked data-memory responder: captures one request, waits WAIT cycles, then
// completes it with a one-cycle ready pulse. Define DM_BYTE_WRITE_EN for byte-enabled writes.
module dm_resp #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
`ifdef DM_BYTE_WRITE_EN
  input  logic [3:0]        be,
`endif
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy
);

  import dm_pkg::*;

  localparam int WAIT_C = (WAIT > DM_WAIT_MAX) ? DM_WAIT_MAX : WAIT;

  dm_state_t state, state_n;
  logic [3:0] cnt;
  logic       take;

  logic                 cap_we;
  logic [ADDR_W-1:0]    cap_addr;
  logic [DM_WORD_W-1:0] cap_wdata;
  logic                 acc_we;
  logic [ADDR_W-1:0]    acc_addr;
  logic [DM_WORD_W-1:0] acc_wdata;
  logic [DM_WORD_W-1:0] mem_rd;
  logic [DM_WORD_W-1:0] rdata_n;
  logic                 store_we;
`ifdef DM_BYTE_WRITE_EN
  logic [3:0]           cap_be;
  logic [3:0]           acc_be;
`endif

  assign take = (state == IDLE) && req;

  // With WAIT=0 the response is formed on the capture edge, so the access view
  // bypasses the request registers while they are being loaded.
  always_comb begin
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
`ifdef DM_BYTE_WRITE_EN
    acc_be    = cap_be;
`endif
    if (take) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
`ifdef DM_BYTE_WRITE_EN
      acc_be    = be;
`endif
    end
  end

  always_comb begin
`ifdef DM_BYTE_WRITE_EN
    rdata_n = acc_we ? dm_byte_merge(mem_rd, acc_wdata, acc_be) : mem_rd;
`else
    rdata_n = acc_we ? acc_wdata : mem_rd;
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (req) state_n = (WAIT_C > 0) ? dm_pkg::WAIT : RESP;
      dm_pkg::WAIT: if (cnt <= 4'd1) state_n = RESP;
      RESP:        state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      ready <= (state_n == RESP);
      busy  <= (state_n != IDLE);
      if (take) begin
        cnt <= 4'(WAIT_C);
      end else if (state == dm_pkg::WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state_n == RESP) begin
        rdata <= rdata_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      cap_we    <= we;
      cap_addr  <= addr;
      cap_wdata <= wdata;
`ifdef DM_BYTE_WRITE_EN
      cap_be    <= be;
`endif
    end
  end

  // The merged word already sits in rdata during RESP, so it doubles as write data.
  assign store_we = (state == RESP) && cap_we;

  dm_store #(
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (store_we),
    .waddr (cap_addr),
    .wdata (rdata),
    .raddr (acc_addr),
    .rdata (mem_rd)
  );

endmodule

// File: tb/tb_dm_resp.sv
// Directed self-checking bench for dm_resp: one instance with WAIT=2, one with WAIT=0.
module tb_dm_resp;

  logic        clk;
  logic        rst;
  logic        req_a, we_a, ready_a, busy_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic [3:0]  be_a;
  logic        req_b, we_b, ready_b, busy_b;
  logic [9:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic [3:0]  be_b;

  int cmp;
  int bad;

  dm_resp #(.ADDR_W(10), .WAIT(2)) u_a (
    .clk   (clk),
    .rst   (rst),
    .req   (req_a),
    .we    (we_a),
    .addr  (addr_a),
    .wdata (wdata_a),
`ifdef DM_BYTE_WRITE_EN
    .be    (be_a),
`endif
    .rdata (rdata_a),
    .ready (ready_a),
    .busy  (busy_a)
  );

  dm_resp #(.ADDR_W(10), .WAIT(0)) u_b (
    .clk   (clk),
    .rst   (rst),
    .req   (req_b),
    .we    (we_b),
    .addr  (addr_b),
    .wdata (wdata_b),
`ifdef DM_BYTE_WRITE_EN
    .be    (be_b),
`endif
    .rdata (rdata_b),
    .ready (ready_b),
    .busy  (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one access, waits (bounded) for ready, drops req in the ready cycle.
  task automatic access(input bit sel, input logic w, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    if (!sel) begin
      req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; be_a = b;
    end else begin
      req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d; be_b = b;
    end
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("busy_during_access", sel ? busy_b : busy_a, 32'd1);
      if (sel ? ready_b : ready_a) begin
        lat = k;
        rd  = sel ? rdata_b : rdata_a;
        break;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    cmp = 0;
    bad = 0;
    rst = 1'b1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0; be_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0; be_b = '0;

    repeat (2) @(negedge clk);
    check("reset_ready", ready_a, 32'd0);
    check("reset_busy", busy_a, 32'd0);
    check("reset_rdata", rdata_a, 32'd0);
    rst = 1'b0;

    // Read of a cleared word, WAIT=2
    access(0, 1'b0, 10'h005, 32'h0, 4'hF, rd, lat);
    check("rd5_latency", lat, 32'd3);
    check("rd5_data", rd, 32'h0000_0000);
    @(negedge clk);
    check("rd5_ready_drops", ready_a, 32'd0);
    check("rd5_busy_drops", busy_a, 32'd0);

    // Write then read back
    access(0, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, rd, lat);
    check("wr10_latency", lat, 32'd3);
    check("wr10_rdata", rd, 32'hDEAD_BEEF);
    access(0, 1'b0, 10'h010, 32'h0, 4'hF, rd, lat);
    check("rd10_data", rd, 32'hDEAD_BEEF);

    // req held high: inputs change every cycle, only cycles 0,4,8 are captured
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("stream_ready", ready_a, (c % 4 == 3) ? 32'd1 : 32'd0);
      if (c % 4 == 3) check("stream_rdata", rdata_a, 32'h100 + 32'(c - 3));
      req_a = 1'b1; we_a = 1'b1; addr_a = 10'h040 + 10'(c); wdata_a = 32'h100 + 32'(c); be_a = 4'hF;
    end
    @(negedge clk);
    req_a = 1'b0;
    check("stream_idle_busy", busy_a, 32'd0);
    access(0, 1'b0, 10'h041, 32'h0, 4'hF, rd, lat);
    check("stream_skipped_addr", rd, 32'h0000_0000);
    access(0, 1'b0, 10'h044, 32'h0, 4'hF, rd, lat);
    check("stream_second_write", rd, 32'h0000_0104);

    // WAIT=0 instance, including address wrap endpoints
    access(1, 1'b1, 10'h3FF, 32'h1234_5678, 4'hF, rd, lat);
    check("w0_wr_latency", lat, 32'd1);
    check("w0_wr_rdata", rd, 32'h1234_5678);
    access(1, 1'b0, 10'h3FF, 32'h0, 4'hF, rd, lat);
    check("w0_rd3ff_latency", lat, 32'd1);
    check("w0_rd3ff_data", rd, 32'h1234_5678);
    access(1, 1'b0, 10'h000, 32'h0, 4'hF, rd, lat);
    check("w0_rd000_data", rd, 32'h0000_0000);

    // Reset in the middle of a write's wait phase
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'h020; wdata_a = 32'hCAFE_F00D; be_a = 4'hF;
    @(negedge clk);
    check("midrst_busy_before", busy_a, 32'd1);
    rst = 1'b1;
    req_a = 1'b0;
    #1;
    check("midrst_ready", ready_a, 32'd0);
    check("midrst_busy", busy_a, 32'd0);
    check("midrst_rdata", rdata_a, 32'd0);
    check("midrst_rdata_b", rdata_b, 32'd0);
    @(negedge clk);
    check("midrst_ready_held", ready_a, 32'd0);
    rst = 1'b0;
    access(0, 1'b0, 10'h020, 32'h0, 4'hF, rd, lat);
    check("midrst_discarded", rd, 32'h0000_0000);
    check("midrst_latency", lat, 32'd3);
    access(0, 1'b0, 10'h010, 32'h0, 4'hF, rd, lat);
    check("midrst_cleared_a", rd, 32'h0000_0000);
    access(1, 1'b0, 10'h3FF, 32'h0, 4'hF, rd, lat);
    check("midrst_cleared_b", rd, 32'h0000_0000);

`ifdef DM_BYTE_WRITE_EN
    access(0, 1'b1, 10'h030, 32'hAABB_CCDD, 4'b1111, rd, lat);
    check("be_full_write", rd, 32'hAABB_CCDD);
    access(0, 1'b1, 10'h030, 32'h1122_3344, 4'b0101, rd, lat);
    check("be_partial_rdata", rd, 32'hAA22_CC44);
    access(0, 1'b0, 10'h030, 32'h0, 4'hF, rd, lat);
    check("be_partial_read", rd, 32'hAA22_CC44);
    access(0, 1'b1, 10'h030, 32'hFFFF_FFFF, 4'b0000, rd, lat);
    check("be_noop_latency", lat, 32'd3);
    check("be_noop_rdata", rd, 32'hAA22_CC44);
    access(0, 1'b0, 10'h030, 32'h0, 4'hF, rd, lat);
    check("be_noop_read", rd, 32'hAA22_CC44);
`else
    access(0, 1'b1, 10'h030, 32'hAABB_CCDD, 4'b1111, rd, lat);
    check("full_write_1", rd, 32'hAABB_CCDD);
    access(0, 1'b1, 10'h030, 32'h1122_3344, 4'b0101, rd, lat);
    check("full_write_2", rd, 32'h1122_3344);
    access(0, 1'b0, 10'h030, 32'h0, 4'hF, rd, lat);
    check("full_write_read", rd, 32'h1122_3344);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
